// File: rtl/cv32e40x_xif_result_buffer_if.sv
// Bundle of the XIF result-side signals: functional-unit offer, commit/kill strobe, core result port.
// The slave modport is the buffer side; the master modport is the environment driving it.
interface cv32e40x_xif_result_buffer_if #(
  parameter int X_ID_WIDTH  = 4,
  parameter int X_RFW_WIDTH = 32
);
  logic                   fu_valid;
  logic                   fu_ready;
  logic [X_ID_WIDTH-1:0]  fu_id;
  logic [X_RFW_WIDTH-1:0] fu_data;
  logic [4:0]             fu_rd;
  logic                   fu_we;

  logic                   commit_valid;
  logic [X_ID_WIDTH-1:0]  commit_id;
  logic                   commit_kill;

  logic                   result_valid;
  logic                   result_ready;
  logic [X_ID_WIDTH-1:0]  result_id;
  logic [X_RFW_WIDTH-1:0] result_data;
  logic [4:0]             result_rd;
  logic                   result_we;

  modport master (
    output fu_valid, fu_id, fu_data, fu_rd, fu_we,
    output commit_valid, commit_id, commit_kill,
    output result_ready,
    input  fu_ready,
    input  result_valid, result_id, result_data, result_rd, result_we
  );

  modport slave (
    input  fu_valid, fu_id, fu_data, fu_rd, fu_we,
    input  commit_valid, commit_id, commit_kill,
    input  result_ready,
    output fu_ready,
    output result_valid, result_id, result_data, result_rd, result_we
  );
endinterface

// File: rtl/cv32e40x_xif_result_buffer.sv
// XIF result buffer: FIFO of completed coprocessor results released only once their ID commits.
// Optional same-cycle bypass for an empty FIFO is enabled by defining XIF_RESULT_BYPASS_EN.
module cv32e40x_xif_result_buffer #(
  parameter int X_ID_WIDTH  = 4,
  parameter int X_RFW_WIDTH = 32,
  parameter int DEPTH       = 4
) (
  input  logic                             clk,
  input  logic                             rst,
  cv32e40x_xif_result_buffer_if.slave      xif,
  output logic                             empty
);

  localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W  = $clog2(DEPTH + 1);
  localparam int NUM_ID = 1 << X_ID_WIDTH;

  typedef struct packed {
    logic [X_ID_WIDTH-1:0]  id;
    logic [X_RFW_WIDTH-1:0] data;
    logic [4:0]             rd;
    logic                   we;
  } entry_t;

  entry_t             mem [DEPTH];
  logic [PTR_W-1:0]   wptr;
  logic [PTR_W-1:0]   rptr;
  logic [CNT_W-1:0]   count;
  logic [NUM_ID-1:0]  committed;
  logic [NUM_ID-1:0]  killed;

  entry_t             head;
  entry_t             fu_entry;
  entry_t             out_entry;
  logic               full;
  logic               head_drop;
  logic               head_present;
  logic               bypass;
  logic               bypass_take;
  logic               pop;
  logic               push;
  logic               clr_en;
  logic [X_ID_WIDTH-1:0] clr_id;
  logic               res_valid;

  assign full  = (count == CNT_W'(DEPTH));
  assign empty = (count == '0);

  assign head     = mem[rptr];
  assign fu_entry = '{id: xif.fu_id, data: xif.fu_data, rd: xif.fu_rd, we: xif.fu_we};

  // Kill takes priority over commit so a killed head is never presented.
  assign head_drop    = !empty && killed[head.id];
  assign head_present = !empty && !killed[head.id] && committed[head.id];

`ifdef XIF_RESULT_BYPASS_EN
  assign bypass = empty && xif.fu_valid && committed[xif.fu_id] && !killed[xif.fu_id];
`else
  assign bypass = 1'b0;
`endif

  assign bypass_take = bypass && xif.result_ready;
  assign pop         = head_drop || (head_present && xif.result_ready);
  assign push        = xif.fu_valid && !full && !bypass_take;
  assign clr_en      = pop || bypass_take;
  assign clr_id      = bypass_take ? xif.fu_id : head.id;

  // Fields are forced to zero while invalid so the storage itself needs no reset.
  always_comb begin
    res_valid = head_present || bypass;
    out_entry = '0;
    if (bypass)            out_entry = fu_entry;
    else if (head_present) out_entry = head;
  end

  assign xif.fu_ready     = !full;
  assign xif.result_valid = res_valid;
  assign xif.result_id    = out_entry.id;
  assign xif.result_data  = out_entry.data;
  assign xif.result_rd    = out_entry.rd;
  assign xif.result_we    = out_entry.we;

  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= fu_entry;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + PTR_W'(1);
      if (pop)  rptr <= rptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // The set is written after the clear so a same-cycle set for the popped ID survives.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      committed <= '0;
      killed    <= '0;
    end else begin
      if (clr_en) begin
        committed[clr_id] <= 1'b0;
        killed[clr_id]    <= 1'b0;
      end
      if (xif.commit_valid) begin
        if (xif.commit_kill) killed[xif.commit_id]    <= 1'b1;
        else                 committed[xif.commit_id] <= 1'b1;
      end
    end
  end

endmodule
